mux_rr_n: RTL and testbench
===========================

MUX_RR_N -- requirements
Module: mux_rr_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 3, meaning the data width of each channel in bits.
REQ-002 The block SHALL have parameter CHANNELS, default 4, meaning the number of input channels (legal range 2..16).
REQ-003 The block SHALL have parameter SEL_W, default 2, meaning the select width (SEL_W >= clog2(CHANNELS)).
REQ-004 clock  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-006 in_data  input  CHANNELS*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 in_valid  input  CHANNELS  per-channel valid.
REQ-008 in_ready  output  CHANNELS  per-channel ready, combinational.
REQ-009 mode  input  1  0 = direct select, 1 = round-robin scan.
REQ-010 sel  input  SEL_W  channel select, used in direct mode only.
REQ-011 out  output  WIDTH  registered output data.
REQ-012 out_chan  output  SEL_W  index of the channel that supplied out.
REQ-013 out_valid  output  1  out holds an unconsumed word.
REQ-014 out_ready  input  1  downstream accepts out when out_valid=1.
REQ-015 err  output  1  sticky invalid-select flag; exists only under MUX_ERR_EN.

Function
REQ-016 load_en SHALL equal (!out_valid || out_ready); in_ready bits SHALL be 0 wherever load_en=0.
REQ-017 Direct mode: in_ready[sel] SHALL equal load_en, all other in_ready bits 0; when in_valid[sel]=1 and load_en=1, the next edge SHALL load out<=channel sel, out_chan<=sel, out_valid<=1.
REQ-018 Round-robin: grant SHALL be the first k with in_valid[k]=1, searching ptr, ptr+1, ... CHANNELS-1, 0, ... ptr-1; in_ready[grant]=load_en, all others 0.
REQ-019 Round-robin: on a transfer, ptr SHALL advance to grant+1, wrapping CHANNELS-1 -> 0; with no in_valid bit set, ptr SHALL hold and no transfer SHALL occur.
REQ-020 Latency SHALL be exactly one clock from input handshake to out_valid=1; sustained throughput SHALL be one word per clock while out_ready=1.
REQ-021 When out_valid=1 and out_ready=1 and no new transfer occurs, out_valid SHALL go 0 on the next edge; out and out_chan SHALL hold their values.
REQ-022 When out_valid=1 and out_ready=0, out, out_chan and out_valid SHALL hold and no input SHALL be accepted.
REQ-023 A simultaneous consume and load SHALL replace out with the new word and keep out_valid=1.
REQ-024 ptr SHALL be retained across mode changes; a mode change SHALL take effect in the same cycle it is presented (combinational grant/in_ready).
REQ-025 Direct mode with sel >= CHANNELS SHALL drive all in_ready bits 0 and load nothing.

Reset
REQ-026 Reset SHALL clear out=0, out_chan=0, out_valid=0, ptr=0, and err=0 (when present).
REQ-027 Reset asserted mid-transfer SHALL win: a pending word SHALL be discarded and in_ready SHALL be all-zero while reset=1.

Configuration
REQ-028 With macro MUX_ERR_EN defined, err SHALL set on the edge after any cycle with mode=0 and sel >= CHANNELS, and SHALL clear only on reset.
REQ-029 Without MUX_ERR_EN, the err port and its logic SHALL be absent and the REQ-025 behaviour SHALL be unchanged.

Verification
REQ-030 Direct: ch0..3 = 1,2,3,4, all valid, out_ready=1, sel stepping 0,1,2,3 -> out = 1,2,3,4 one clock behind, out_chan = 0,1,2,3.
REQ-031 Round-robin: all four valid, out_ready=1 -> out_chan sequence 0,1,2,3,0; in_valid = 4'b1010 -> sequence 1,3,1,3.
REQ-032 Backpressure: out_ready=0 for 3 clocks with out_valid=1 -> out is stable and in_ready = 0; on release, the next word follows with no gap.
REQ-033 Wrap/skip: ptr=3 with only ch0 valid -> ch0 granted and ptr becomes 1.
REQ-034 Reset issued mid-stream while out_valid=1 -> next clock out_valid=0, out=0, and the first post-reset round-robin grant is ch0.
REQ-035 With MUX_ERR_EN, CHANNELS=3, sel=3 in direct mode -> no load, err=1 sticky until reset.

Source files
------------

// File: rtl/mux_rr_n.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_n
// Purpose  : N-channel valid/ready multiplexer with a registered output
//            stage. Direct mode forwards the channel picked by sel.
//            Round-robin mode scans from a rotating pointer. Optional
//            sticky invalid-select flag is built only when the macro
//            MUX_ERR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mux_rr_n #(
   parameter int WIDTH    = 3,
   parameter int CHANNELS = 4,
   parameter int SEL_W    = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   output logic [WIDTH-1:0]          out,
   output logic [SEL_W-1:0]          out_chan,
   output logic                      out_valid,
   input  logic                      out_ready
`ifdef MUX_ERR_EN
   ,
   output logic                      err
`endif
);

   localparam int                C_SELW1    = SEL_W + 1;
   // Channel count one bit wider than sel so sel >= CHANNELS compares cleanly
   localparam logic [SEL_W:0]    C_CHANNELS = C_SELW1'(CHANNELS);
   localparam logic [SEL_W-1:0]  C_LAST     = SEL_W'(CHANNELS - 1);

   logic                  load_en;
   logic                  sel_ok;
   logic [CHANNELS-1:0]   vrot;
   logic                  rr_found;
   int                    rr_sum;
   logic [SEL_W-1:0]      rr_grant;
   logic [SEL_W-1:0]      grant;
   logic                  grant_en;
   logic                  grant_vld;
   logic [WIDTH-1:0]      data_sel;
   logic                  xfer;

   logic [SEL_W-1:0]      ptr_q,   ptr_d;
   logic [WIDTH-1:0]      out_q,   out_d;
   logic [SEL_W-1:0]      chan_q,  chan_d;
   logic                  valid_q, valid_d;

   // Round-robin search: rotate valids so bit 0 is the pointer position,
   // take the first set bit and map it back to an absolute channel index
   always_comb begin
      vrot     = CHANNELS'({in_valid, in_valid} >> ptr_q);
      rr_found = 1'b0;
      rr_sum   = 0;
      rr_grant = '0;
      for (int j = 0; j < CHANNELS; j++) begin
         if (!rr_found && vrot[j]) begin
            rr_found = 1'b1;
            rr_sum   = int'(ptr_q) + j;
            if (rr_sum >= CHANNELS) begin
               rr_sum = rr_sum - CHANNELS;
            end
            rr_grant = SEL_W'(rr_sum);
         end
      end
   end

   // Grant selection, ready generation and next-state computation
   always_comb begin
      load_en   = !valid_q || out_ready;
      sel_ok    = {1'b0, sel} < C_CHANNELS;
      grant_en  = mode ? rr_found : sel_ok;
      grant     = mode ? rr_grant : sel;
      grant_vld = 1'b0;
      data_sel  = '0;
      in_ready  = '0;
      // An out-of-range sel matches no channel, so nothing is readied
      for (int k = 0; k < CHANNELS; k++) begin
         if (grant == SEL_W'(k)) begin
            grant_vld   = in_valid[k];
            data_sel    = in_data[k*WIDTH +: WIDTH];
            in_ready[k] = grant_en && load_en && !reset;
         end
      end
      xfer = grant_en && grant_vld && load_en && !reset;

      ptr_d   = ptr_q;
      out_d   = out_q;
      chan_d  = chan_q;
      valid_d = valid_q;
      if (xfer) begin
         out_d   = data_sel;
         chan_d  = grant;
         valid_d = 1'b1;
         // Only round-robin transfers move the pointer; direct mode keeps it
         if (mode) begin
            ptr_d = (grant == C_LAST) ? '0 : grant + 1'b1;
         end
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   // Output register and round-robin pointer
   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_q   <= '0;
         out_q   <= '0;
         chan_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         out_q   <= out_d;
         chan_q  <= chan_d;
         valid_q <= valid_d;
      end
   end

   assign out       = out_q;
   assign out_chan  = chan_q;
   assign out_valid = valid_q;

`ifdef MUX_ERR_EN
   logic err_q, err_d;

   // Sticky flag: any direct-mode cycle with an out-of-range select
   always_comb begin
      err_d = err_q || (!mode && !sel_ok);
   end

   // Error flag register, cleared only by reset
   always_ff @(posedge clock) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_rr_n
// Purpose  : Scoreboard bench for mux_rr_n. Stimulus process predicts each
//            accepted word from a behavioural model and queues it; a monitor
//            pops and compares whenever the DUT output is consumed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_rr_n;
   localparam int W  = 3;
   localparam int CH = 4;
   localparam int SW = 2;

   logic               clock = 1'b0;
   logic               reset;
   logic [CH*W-1:0]    in_data;
   logic [CH-1:0]      in_valid;
   logic [CH-1:0]      in_ready;
   logic               mode;
   logic [SW-1:0]      sel;
   logic [W-1:0]       out;
   logic [SW-1:0]      out_chan;
   logic               out_valid;
   logic               out_ready;
`ifdef MUX_ERR_EN
   logic               err;
`endif

   // second instance with a non-power-of-two channel count
   logic               r3;
   logic [8:0]         d3;
   logic [2:0]         v3, rdy3;
   logic               md3;
   logic [1:0]         s3;
   logic [2:0]         o3;
   logic [1:0]         c3;
   logic               ov3, ordy3;
`ifdef MUX_ERR_EN
   logic               err3;
`endif

   mux_rr_n #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW)) u_dut (
      .clock     (clock),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .sel       (sel),
      .out       (out),
      .out_chan  (out_chan),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef MUX_ERR_EN
      ,
      .err       (err)
`endif
   );

   mux_rr_n #(.WIDTH(3), .CHANNELS(3), .SEL_W(2)) u_dut3 (
      .clock     (clock),
      .reset     (r3),
      .in_data   (d3),
      .in_valid  (v3),
      .in_ready  (rdy3),
      .mode      (md3),
      .sel       (s3),
      .out       (o3),
      .out_chan  (c3),
      .out_valid (ov3),
      .out_ready (ordy3)
`ifdef MUX_ERR_EN
      ,
      .err       (err3)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [W-1:0]  d;
      logic [SW-1:0] c;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   tests = 0;
   int   fails = 0;
   int   m_ptr = 0;
   bit   m_valid = 1'b0;
   logic [W-1:0] held;
   logic [CH*W-1:0] d1234 = {3'd4, 3'd3, 3'd2, 3'd1};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   // first valid channel at or after ptr, wrapping; -1 when none
   function automatic int rr_pick(input int ptr, input logic [CH-1:0] v);
      for (int i = 0; i < CH; i++) begin
         int k = (ptr + i) % CH;
         if (((v >> k) & CH'(1)) != 0) return k;
      end
      return -1;
   endfunction

   // called just after a rising edge: drive one cycle, predict, advance
   task automatic step(input bit rst, input bit md, input logic [SW-1:0] s,
                       input logic [CH-1:0] v, input logic [CH*W-1:0] d, input bit ordy);
      int g;
      bit le;
      bit gv;
      logic [CH-1:0] er;
      exp_t e_new;
      reset = rst; mode = md; sel = s; in_valid = v; in_data = d; out_ready = ordy;
      #1;
      check("out_valid", 32'(out_valid), 32'(m_valid));
      le = !m_valid || ordy;
      if (md) g = rr_pick(m_ptr, v);
      else    g = (int'(s) < CH) ? int'(s) : -1;
      er = '0;
      gv = 1'b0;
      if (g >= 0) begin
         gv = ((v >> g) & CH'(1)) != 0;
         if (!rst && le) er = CH'(1) << g;
      end
      check("in_ready", 32'(in_ready), 32'(er));
      if (rst) begin
         sb.delete();
         m_valid = 1'b0;
         m_ptr   = 0;
      end else if (le && gv) begin
         e_new.d = W'(d >> (g*W));
         e_new.c = SW'(g);
         sb.push_back(e_new);
         m_valid = 1'b1;
         if (md) m_ptr = (g + 1) % CH;
      end else if (ordy) begin
         m_valid = 1'b0;
      end
      @(posedge clock);
      #1;
   endtask

   // monitor: a word held with out_ready=1 is consumed at the next edge
   initial begin
      forever begin
         @(negedge clock);
         if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_word: got out=%0d chan=%0d, expected none", out, out_chan);
            end else begin
               mon_e = sb.pop_front();
               check("out", 32'(out), 32'(mon_e.d));
               check("out_chan", 32'(out_chan), 32'(mon_e.c));
            end
         end
      end
   end

   initial begin
      reset = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b1;
      r3 = 1'b1; md3 = 1'b0; s3 = '0; v3 = '0; d3 = '0; ordy3 = 1'b1;
      @(posedge clock);
      #1;
      step(1, 0, 0, '0, '0, 1);
      check("rst_out", 32'(out), 32'(0));
      check("rst_out_chan", 32'(out_chan), 32'(0));
      check("rst_out_valid", 32'(out_valid), 32'(0));

      // direct mode, sel stepping
      for (int s = 0; s < 4; s++) step(0, 0, SW'(s), 4'hF, d1234, 1);
      // round-robin all valid, then alternating channels
      for (int i = 0; i < 5; i++) step(0, 1, 0, 4'hF, d1234, 1);
      for (int i = 0; i < 4; i++) step(0, 1, 0, 4'b1010, d1234, 1);

      // backpressure: word must be stable, inputs refused
      step(0, 1, 0, 4'hF, d1234, 1);
      held = out;
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 4'hF, d1234, 0);
         check("hold_out", 32'(out), 32'(held));
      end
      step(0, 1, 0, 4'hF, d1234, 1);
      step(0, 1, 0, 4'hF, d1234, 1);

      // wrap/skip: pointer parked at 3, only ch0 valid
      step(1, 1, 0, '0, '0, 1);
      step(0, 1, 0, 4'b0100, d1234, 1);
      step(0, 1, 0, 4'b0001, d1234, 1);
      step(0, 1, 0, 4'b0011, d1234, 1);

      // reset in mid-stream with a pending word
      step(0, 1, 0, 4'hF, d1234, 0);
      step(0, 1, 0, 4'hF, d1234, 0);
      step(1, 1, 0, 4'hF, d1234, 1);
      check("midrst_out", 32'(out), 32'(0));
      check("midrst_valid", 32'(out_valid), 32'(0));
      step(0, 1, 0, 4'hF, d1234, 1);

      // randomized traffic, mode changes, backpressure, occasional reset
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) == 0), 1'($urandom), SW'($urandom),
              CH'($urandom), (CH*W)'($urandom), ($urandom_range(0, 9) < 7));
      end

      // drain
      for (int i = 0; i < 3; i++) step(0, 0, 0, '0, '0, 1);
      check("sb_empty", 32'(sb.size()), 32'(0));
`ifdef MUX_ERR_EN
      check("err_main", 32'(err), 32'(0));
`endif

      // three-channel instance: out-of-range select
      r3 = 1'b0; md3 = 1'b0; s3 = 2'd3; v3 = 3'b111; d3 = {3'd5, 3'd6, 3'd7}; ordy3 = 1'b1;
      #1;
      check("c3_bad_ready", 32'(rdy3), 32'(0));
      @(posedge clock);
      #1;
      check("c3_bad_noload", 32'(ov3), 32'(0));
`ifdef MUX_ERR_EN
      check("c3_err_set", 32'(err3), 32'(1));
`endif
      s3 = 2'd2;
      #1;
      check("c3_ready2", 32'(rdy3), 32'(3'b100));
      @(posedge clock);
      #1;
      check("c3_valid", 32'(ov3), 32'(1));
      check("c3_out", 32'(o3), 32'(5));
      check("c3_chan", 32'(c3), 32'(2));
`ifdef MUX_ERR_EN
      check("c3_err_sticky", 32'(err3), 32'(1));
`endif
      r3 = 1'b1;
      #1;
      check("c3_rst_ready", 32'(rdy3), 32'(0));
      @(posedge clock);
      #1;
      check("c3_rst_valid", 32'(ov3), 32'(0));
`ifdef MUX_ERR_EN
      check("c3_err_clr", 32'(err3), 32'(0));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
